// File: rtl/alu_seq_nbits.sv
// Registered WIDTH-bit ALU: logic ops, add/sub with Z/N/C/V flags, and
// iterative one-bit-per-cycle logical shifts behind valid/ready handshakes.
`timescale 1ns/1ps
module alu_seq_nbits #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] R,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             last_q, last_d;
  logic             shl_q, shl_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             ov_q, ov_d;

  logic             accept;
  logic [SHW-1:0]   s_amt;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;

  assign in_ready  = (state_q == IDLE) && (!ov_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign s_amt     = B[SHW-1:0];
  assign R         = r_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign C         = c_q;
  assign V         = v_q;
  assign out_valid = ov_q;

  // Single-edge datapath; subtraction is A + ~B + 1 so carry means no borrow
  always_comb begin
    is_sub = (op == 3'b101);
    b_eff  = is_sub ? ~B : B;
    sum    = {1'b0, A} + {1'b0, b_eff} + (WIDTH+1)'(is_sub);
    alu_r  = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    case (op)
      3'b000: alu_r = A & B;
      3'b001: alu_r = A | B;
      3'b010: alu_r = A ^ B;
      3'b011: alu_r = ~A;
      3'b100: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
      end
      3'b101: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (A[MSB] != B[MSB]) && (sum[MSB] != A[MSB]);
      end
      default: alu_r = A;
    endcase
  end

  always_comb begin
    sh_next = shl_q ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
    sh_out  = shl_q ? sh_q[MSB] : sh_q[0];
  end

  // Next-state and output-register logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    last_d  = last_q;
    shl_d   = shl_q;
    r_d     = r_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    ov_d    = ov_q && !out_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op[2:1] == 2'b11 && s_amt != '0) begin
            sh_d    = A;
            cnt_d   = s_amt;
            last_d  = 1'b0;
            shl_d   = !op[0];
            state_d = SHIFT;
          end else begin
            r_d  = alu_r;
            z_d  = (alu_r == '0);
            n_d  = alu_r[MSB];
            c_d  = alu_c;
            v_d  = alu_v;
            ov_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        sh_d   = sh_next;
        last_d = sh_out;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          r_d     = sh_next;
          z_d     = (sh_next == '0);
          n_d     = sh_next[MSB];
          c_d     = last_d;
          v_d     = 1'b0;
          ov_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      last_q  <= 1'b0;
      shl_q   <= 1'b0;
      r_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      last_q  <= last_d;
      shl_q   <= shl_d;
      r_q     <= r_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_nbits.sv
// Scoreboard bench for alu_seq_nbits at WIDTH=8: directed vectors push
// expected results, a negedge monitor pops and compares on each transfer.
`timescale 1ns/1ps
module tb_alu_seq_nbits;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] A, B;
  logic [2:0] op;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] R;
  logic       Z, N, C, V;
  logic       out_valid;
  logic       out_ready;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } res_t;

  res_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  alu_seq_nbits #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .R         (R),
    .Z         (Z),
    .N         (N),
    .C         (C),
    .V         (V),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expect_res(input string nm, input logic [7:0] r,
                            input logic z, input logic n, input logic c, input logic v);
    res_t e;
    e.r = r; e.z = z; e.n = n; e.c = c; e.v = v;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Presents one operation; returns 1ns after the accept edge
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
    A = a; B = b; op = o; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin : monitor
    res_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got R=0x%0h expected no result", R);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          chk({nm, "_R"}, 32'(R), 32'(e.r));
          chk({nm, "_ZNCV"}, {28'b0, Z, N, C, V}, {28'b0, e.z, e.n, e.c, e.v});
        end
      end
    end
  end

  initial begin : stimulus
    A = '0; B = '0; op = '0; in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_R", 32'(R), 32'h0);
    chk("reset_ZNCV", {28'b0, Z, N, C, V}, 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    #1 chk("reset_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;

    expect_res("add_ovf", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    send(8'h7F, 8'h01, 3'b100);
    chk("add_latency_out_valid", 32'(out_valid), 32'h1);
    expect_res("sub_equal", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    send(8'h05, 8'h05, 3'b101);
    expect_res("xor_zero", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'hA5, 8'hA5, 3'b010);
    expect_res("sub_borrow", 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'h03, 8'h05, 3'b101);
    expect_res("sub_ovf", 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h80, 8'h01, 3'b101);
    expect_res("add_carry", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    send(8'hFF, 8'h01, 3'b100);
    expect_res("or", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h50, 8'h0A, 3'b001);

    // SHL by 2; a request presented mid-shift must be ignored
    expect_res("shl2", 8'h04, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'hC1, 8'h02, 3'b110);
    chk("shl_in_ready_c1", 32'(in_ready), 32'h0);
    chk("shl_out_valid_c1", 32'(out_valid), 32'h0);
    A = 8'hFF; B = 8'hFF; op = 3'b000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("shl_in_ready_c2", 32'(in_ready), 32'h0);
    chk("shl_out_valid_c2", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    chk("shl_latency_out_valid", 32'(out_valid), 32'h1);

    // SHR by 3: carry must be the last bit shifted out, not the first
    expect_res("shr3", 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'h84, 8'h03, 3'b111);
    repeat (2) @(posedge clk);
    #1 chk("shr3_out_valid_early", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    chk("shr3_latency_out_valid", 32'(out_valid), 32'h1);

    expect_res("shr_s0", 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'h81, 8'h08, 3'b111);
    chk("shr_s0_latency_out_valid", 32'(out_valid), 32'h1);
    @(posedge clk); #1;

    // Backpressure, then simultaneous transfer and new accept
    out_ready = 1'b0;
    expect_res("bp_add", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h10, 8'h20, 3'b100);
    chk("bp_out_valid", 32'(out_valid), 32'h1);
    A = 8'h0F; B = 8'h00; op = 3'b011; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("bp_in_ready_low", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk("bp_R_held", 32'(R), 32'h30);
      chk("bp_out_valid_held", 32'(out_valid), 32'h1);
    end
    expect_res("bp_not", 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1 chk("bp_in_ready_release", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_R", 32'(R), 32'hF0);
    chk("b2b_out_valid", 32'(out_valid), 32'h1);

    // Reset in the middle of a 5-step shift: no result may appear
    send(8'h01, 8'h05, 3'b110);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_R", 32'(R), 32'h0);
    chk("midreset_ZNCV", {28'b0, Z, N, C, V}, 32'h0);
    chk("midreset_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("midreset_in_ready", 32'(in_ready), 32'h1);
    repeat (6) @(posedge clk);
    #1 chk("midreset_no_result", 32'(out_valid), 32'h0);

    expect_res("post_reset_add", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h01, 8'h02, 3'b100);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
